gdb_mem_master: RTL and testbench
=================================

# gdb_mem_master

Bus initiator on the picorv32 native memory interface, used by the GDB server to reach target memory over the real bus instead of through backdoor accesses. It accepts a byte-granular read or write command, splits it into word-aligned native-bus transactions with the correct `mem_wstrb`, and streams data bytes in or out over valid/ready handshakes. It sits between the server's command logic and the memory-side mux that feeds the simulated memory model.

## Interface

Parameters:
- `LEN_W`, default 8: width of `cmd_len`; byte count is `cmd_len + 1`, giving 1..256 bytes.
- `TIMEOUT`, default 1024: maximum cycles `mem_valid` may wait for `mem_ready` before the command aborts with an error.

Ports:
- `clk`  in  1  clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  32  start byte address; any alignment.
- `cmd_len`  in  LEN_W  byte count minus one.
- `wdat_valid` / `wdat_ready` / `wdat`  in / out / 8  write byte stream, in ascending address order.
- `rdat_valid` / `rdat_ready` / `rdat`  out / in / 8  read byte stream, in ascending address order.
- `done`  out  1  one-cycle pulse at command end.
- `err`  out  1  valid with `done`; 1 = timeout abort.
- `mem_valid`, `mem_instr`, `mem_addr[31:0]`, `mem_wdata[31:0]`, `mem_wstrb[3:0]`  out: native-bus request.
- `mem_ready`, `mem_rdata[31:0]`  in: native-bus response.

## Operation

- **States:** IDLE, WFILL, WBUS, RBUS, RDRAIN, DONE.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid`: latch `addr` and `remaining = cmd_len + 1`.
  - Go to WFILL if `cmd_write`, otherwise RBUS.
- **WFILL**
  - `wdat_ready` = 1.
  - Each accepted byte goes to lane `addr[1:0]` of the word buffer and sets that lane's strobe bit. Then `addr` increments and `remaining` decrements.
  - Go to WBUS when the accepted byte fills lane 3 or `remaining` reaches 0.
- **WBUS**
  - `mem_valid` = 1.
  - `mem_addr` = word address (low two bits 0).
  - `mem_wdata` = word buffer; `mem_wstrb` = collected lanes.
  - On `mem_ready`: clear the strobes. Go to WFILL if `remaining` ≠ 0, otherwise DONE.
- **RBUS**
  - `mem_valid` = 1, `mem_wstrb` = 0, `mem_addr` = word address.
  - On `mem_ready`: capture `mem_rdata` and go to RDRAIN.
- **RDRAIN**
  - `rdat_valid` = 1; `rdat` = captured lane `addr[1:0]`.
  - Each accepted byte increments `addr` and decrements `remaining`.
  - After lane 3 or the last byte: go to RBUS if `remaining` ≠ 0, otherwise DONE.
- **DONE**
  - `done` = 1 for one cycle; `err` reflects the abort flag.
  - Return to IDLE.
- **Bus rules**
  - `mem_instr` is always 0.
  - While `mem_valid` is high, `mem_addr`, `mem_wdata` and `mem_wstrb` are stable.
  - `mem_valid` drops in the cycle after `mem_ready`.
  - Each transaction touches exactly one aligned word; `mem_wstrb` is never 0 on a write.
- **Timeout**
  - A wait counter increments every WBUS/RBUS cycle without `mem_ready` and clears on entry to either state.
  - When it reaches `TIMEOUT`: drop `mem_valid`, set the abort flag, discard the remaining bytes (no further `wdat_ready` or `rdat_valid`), go to DONE.
- **Address arithmetic:** 32-bit, wraps from 0xFFFFFFFF to 0x00000000.

## Timing

- **Reset values:** all outputs 0 except `cmd_ready` = 1. Reset in any state returns to IDLE on the next edge, with `mem_valid` = 0 from that edge. No partial write is completed.
- `mem_valid` rises on the edge after the last byte of a word is accepted (write) or the edge after entering RBUS.
- `rdat_valid` rises one cycle after the `mem_ready` cycle.
- **Zero-wait bus** (`mem_ready` in the first `mem_valid` cycle): an aligned 4-byte write with continuous `wdat_valid` takes 4 WFILL + 1 WBUS cycles; `done` pulses on the next edge.
- `mem_ready` seen outside WBUS/RBUS is ignored.
- `done` is never high while `cmd_ready` is high.

## Structure

- Package `gdb_mem_pkg`: state enum, lane-mask constants, `WORD_BYTES = 4`.
- Optional sub-module `gdb_mem_lane`: byte-lane pack/unpack (lane index → strobe and byte mux), shared by the write and read paths.
- Everything else lives in one FSM module.

## Test plan

- **Unaligned write across words:** write addr 0x102, len 3, bytes AA BB CC DD.
  - Transaction 1: `mem_addr` 0x100, wstrb 1100, wdata 0xBBAA_xxxx.
  - Transaction 2: `mem_addr` 0x104, wstrb 0011, wdata 0xxxxx_DDCC.
  - `done` = 1, `err` = 0.
- **Unaligned read with back-pressure:** memory 0x200 = 0x44332211, 0x204 = 0x88776655; read addr 0x203, len 1, `rdat_ready` toggling.
  - `rdat` stream: 44, 55; two read transactions.
- **Random `mem_ready` (pseudo-random ~50%):** 256-byte write then readback from 0x0.
  - Data matches; `mem_addr`/`mem_wdata`/`mem_wstrb` stable during every wait.
- **Timeout:** `mem_ready` tied 0; read addr 0x10 len 0.
  - `mem_valid` drops after `TIMEOUT` cycles; `done` = 1 with `err` = 1; `rdat_valid` never asserts.
- **Wrap-around:** write addr 0xFFFFFFFE, len 3.
  - Transactions at 0xFFFFFFFC (wstrb 1100) and 0x00000000 (wstrb 0011).
- **Reset mid-WBUS:** assert `reset` while `mem_valid` = 1.
  - Next edge: `mem_valid` = 0, `cmd_ready` = 1, `done` = 0.
  - A following aligned read completes normally.

Source files
------------

// File: rtl/gdb_mem_master_pkg.sv
// Shared types and constants for the GDB memory master: FSM states,
// byte-lane masks and the lane-to-strobe helper.
package gdb_mem_pkg;

  localparam int WORD_BYTES = 4;

  localparam logic [3:0] LANE0_MASK = 4'b0001;
  localparam logic [3:0] LANE1_MASK = 4'b0010;
  localparam logic [3:0] LANE2_MASK = 4'b0100;
  localparam logic [3:0] LANE3_MASK = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WFILL  = 3'd1,
    S_WBUS   = 3'd2,
    S_RBUS   = 3'd3,
    S_RDRAIN = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    case (lane)
      2'd0:    return LANE0_MASK;
      2'd1:    return LANE1_MASK;
      2'd2:    return LANE2_MASK;
      default: return LANE3_MASK;
    endcase
  endfunction

endpackage

// File: rtl/gdb_mem_master_if.sv
// picorv32 native memory bus between the GDB memory master and the memory mux.
// Handshake: a transfer completes on a rising edge where mem_valid and
// mem_ready are both high; the request fields stay stable while mem_valid waits.
interface gdb_mem_master_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/gdb_mem_lane.sv
// Byte-lane helper: maps a lane index to its write strobe and selects that
// lane's byte out of a 32-bit word.
module gdb_mem_lane
  import gdb_mem_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [3:0]  strb,
  output logic [7:0]  lane_byte
);

  always_comb begin
    strb      = lane_mask(lane);
    lane_byte = word[8*lane +: 8];
  end

endmodule

// File: rtl/gdb_mem_master.sv
// Byte-granular read/write command engine that issues word-aligned
// transactions on the picorv32 native bus for the GDB server.
module gdb_mem_master
  import gdb_mem_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wdat_valid,
  output logic             wdat_ready,
  input  logic [7:0]       wdat,
  output logic             rdat_valid,
  input  logic             rdat_ready,
  output logic [7:0]       rdat,
  output logic             done,
  output logic             err,
  gdb_mem_master_if.master bus,
  output state_t           dbg_state
);

  localparam int REM_W = LEN_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [31:0]      addr;
  logic [29:0]      word_addr;
  logic [REM_W-1:0] remaining;
  logic [31:0]      wbuf;
  logic [3:0]       strb;
  logic [31:0]      rbuf;
  logic [CNT_W-1:0] wait_cnt;
  logic             abort;

  logic [3:0]  lane_strb;
  logic [7:0]  lane_byte;
  logic [31:0] addr_inc;
  logic        last_byte;
  logic        word_end;
  logic        bus_state;
  logic        bus_tmo;

  gdb_mem_lane u_lane (
    .lane      (addr[1:0]),
    .word      (rbuf),
    .strb      (lane_strb),
    .lane_byte (lane_byte)
  );

  assign addr_inc  = addr + 32'd1;
  assign last_byte = (remaining == REM_W'(1));
  assign word_end  = (addr[1:0] == 2'd3);
  assign bus_state = (state == S_WBUS) || (state == S_RBUS);
  assign bus_tmo   = bus_state && !bus.mem_ready && (wait_cnt == TMO_LAST);
  assign dbg_state = state;

  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    wdat_ready    = 1'b0;
    rdat_valid    = 1'b0;
    rdat          = 8'h00;
    done          = 1'b0;
    err           = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_instr = 1'b0;
    bus.mem_addr  = {word_addr, 2'b00};
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'h0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = cmd_write ? S_WFILL : S_RBUS;
      end
      S_WFILL: begin
        wdat_ready = 1'b1;
        if (wdat_valid && (word_end || last_byte)) state_nxt = S_WBUS;
      end
      S_WBUS: begin
        bus.mem_valid = 1'b1;
        bus.mem_wdata = wbuf;
        bus.mem_wstrb = strb;
        if (bus.mem_ready)  state_nxt = (remaining != '0) ? S_WFILL : S_DONE;
        else if (bus_tmo)   state_nxt = S_DONE;
      end
      S_RBUS: begin
        bus.mem_valid = 1'b1;
        if (bus.mem_ready)  state_nxt = S_RDRAIN;
        else if (bus_tmo)   state_nxt = S_DONE;
      end
      S_RDRAIN: begin
        rdat_valid = 1'b1;
        rdat       = lane_byte;
        if (rdat_ready && (word_end || last_byte))
          state_nxt = last_byte ? S_DONE : S_RBUS;
      end
      S_DONE: begin
        done      = 1'b1;
        err       = abort;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      addr      <= 32'h0;
      word_addr <= 30'h0;
      remaining <= '0;
      wbuf      <= 32'h0;
      strb      <= 4'h0;
      rbuf      <= 32'h0;
      wait_cnt  <= '0;
      abort     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr      <= cmd_addr;
            word_addr <= cmd_addr[31:2];
            remaining <= {1'b0, cmd_len} + REM_W'(1);
            strb      <= 4'h0;
            abort     <= 1'b0;
          end
        end
        S_WFILL: begin
          if (wdat_valid) begin
            for (int i = 0; i < WORD_BYTES; i++)
              if (lane_strb[i]) wbuf[8*i +: 8] <= wdat;
            strb      <= strb | lane_strb;
            word_addr <= addr[31:2];
            addr      <= addr_inc;
            remaining <= remaining - REM_W'(1);
          end
        end
        S_WBUS, S_RBUS: begin
          if (bus.mem_ready) begin
            wait_cnt <= '0;
            if (state == S_WBUS) strb <= 4'h0;
            else                 rbuf <= bus.mem_rdata;
          end else if (bus_tmo) begin
            // Abort drops whatever bytes are left; the write buffer is discarded.
            wait_cnt <= '0;
            strb     <= 4'h0;
            abort    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_RDRAIN: begin
          if (rdat_ready) begin
            addr      <= addr_inc;
            word_addr <= addr_inc[31:2];
            remaining <= remaining - REM_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gdb_mem_master.sv
// Bench for gdb_mem_master: randomized commands against a byte-level memory
// model, with a bus/byte/done scoreboard fed by independent monitors.
module tb_gdb_mem_master;
  import gdb_mem_pkg::*;

  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_write = 1'b0;
  logic [31:0]      cmd_addr = 32'h0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             wdat_valid = 1'b0;
  logic             wdat_ready;
  logic [7:0]       wdat = 8'h0;
  logic             rdat_valid;
  logic             rdat_ready;
  logic [7:0]       rdat;
  logic             done;
  logic             err;
  state_t           dbg_state;

  gdb_mem_master_if bus ();

  gdb_mem_master #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .wdat_valid (wdat_valid),
    .wdat_ready (wdat_ready),
    .wdat       (wdat),
    .rdat_valid (rdat_valid),
    .rdat_ready (rdat_ready),
    .rdat       (rdat),
    .done       (done),
    .err        (err),
    .bus        (bus.master),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [68:0] exp_q[$];      // {is_write, word addr, wstrb, wdata masked by wstrb}
  logic [7:0]  exp_rd_q[$];
  logic        exp_done_q[$];
  bit [7:0]    ref_mem [bit [31:0]];
  bit [7:0]    bus_mem [bit [31:0]];
  logic [7:0]  data_q[$];
  int          ready_mode = 1;  // 0 random, 1 always, 2 never
  int          rrdy_mode = 2;   // 0 random, 1 toggle, 2 always
  int          gap_pct = 0;
  int          valid_cycles = 0;
  bit          over = 1'b0;

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  function automatic bit [7:0] ref_rd(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic bit [7:0] bus_rd(input bit [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : 8'h00;
  endfunction

  task automatic preload(input bit [31:0] a, input bit [7:0] d);
    ref_mem[a] = d;
    bus_mem[a] = d;
  endtask

  task automatic fill4(input logic [7:0] a, b, c, d);
    data_q.delete();
    data_q.push_back(a); data_q.push_back(b); data_q.push_back(c); data_q.push_back(d);
  endtask

  // ---------------- memory slave + bus monitor ----------------
  initial begin : slave
    logic        snap_valid;
    logic [67:0] snap;
    int          waited;
    logic        rdy;
    logic [31:0] word;
    logic [31:0] masked;
    snap_valid = 1'b0;
    waited = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_valid) begin
        valid_cycles++;
        if (snap_valid)
          check("bus_stable", {bus.mem_addr, bus.mem_wstrb, bus.mem_wdata}, snap);
        case (ready_mode)
          1:       rdy = 1'b1;
          2:       rdy = 1'b0;
          default: rdy = (waited >= 8) || ($urandom_range(0, 1) == 1);
        endcase
        word = bus.mem_addr & 32'hFFFF_FFFC;
        bus.mem_ready = rdy;
        bus.mem_rdata = {bus_rd(word + 3), bus_rd(word + 2), bus_rd(word + 1), bus_rd(word)};
        if (rdy) begin
          masked = 32'h0;
          for (int i = 0; i < 4; i++)
            if (bus.mem_wstrb[i]) begin
              masked[8*i +: 8] = bus.mem_wdata[8*i +: 8];
              bus_mem[word + i] = bus.mem_wdata[8*i +: 8];
            end
          if (exp_q.size() == 0) unexpected("bus_txn_extra");
          else check("bus_txn", {|bus.mem_wstrb, bus.mem_addr, bus.mem_wstrb, masked}, exp_q.pop_front());
          snap_valid = 1'b0;
          waited = 0;
        end else begin
          snap_valid = 1'b1;
          snap = {bus.mem_addr, bus.mem_wstrb, bus.mem_wdata};
          waited++;
        end
      end else begin
        snap_valid = 1'b0;
        waited = 0;
        // Stray mem_ready outside a request must be ignored by the master.
        bus.mem_ready = (ready_mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.mem_rdata = $urandom;
      end
    end
  end

  // ---------------- read-stream sink + done monitor ----------------
  initial begin : sink
    rdat_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rrdy_mode)
        1:       rdat_ready = ~rdat_ready;
        2:       rdat_ready = 1'b1;
        default: rdat_ready = 1'($urandom_range(0, 1));
      endcase
      if (rdat_valid && rdat_ready) begin
        if (exp_rd_q.size() == 0) unexpected("rdat_extra");
        else check("rdat", rdat, exp_rd_q.pop_front());
      end
      if (done) begin
        check("done_with_cmd_ready", cmd_ready, 1'b0);
        if (exp_done_q.size() == 0) unexpected("done_extra");
        else check("done_err", err, exp_done_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic feed(input logic [7:0] bytes[$]);
    int idx = 0;
    bit acc = 1'b0;
    while (1) begin
      if (acc) idx++;
      if (idx >= bytes.size() || over) begin
        wdat_valid = 1'b0;
        break;
      end
      wdat_valid = ($urandom_range(0, 99) >= gap_pct);
      wdat = bytes[idx];
      acc = wdat_valid && wdat_ready;
      @(negedge clk);
    end
  endtask

  // Reference model: bytes grouped by aligned word, one transaction per word run.
  task automatic model_cmd(input bit wr, input bit [31:0] addr, input int len,
                           input logic [7:0] bytes[$]);
    bit [31:0] cur = 32'h0;
    bit [3:0]  s = 4'h0;
    bit [31:0] d = 32'h0;
    bit        open = 1'b0;
    for (int i = 0; i <= len; i++) begin
      bit [31:0] a = addr + i;
      if (open && (a[31:2] != cur[31:2])) begin
        exp_q.push_back({wr, cur, s, d});
        open = 1'b0;
      end
      if (!open) begin
        cur = a & 32'hFFFF_FFFC;
        s = 4'h0;
        d = 32'h0;
        open = 1'b1;
      end
      if (wr) begin
        s[a[1:0]] = 1'b1;
        d[8*a[1:0] +: 8] = bytes[i];
        ref_mem[a] = bytes[i];
      end else begin
        exp_rd_q.push_back(ref_rd(a));
      end
    end
    exp_q.push_back({wr, cur, s, d});
  endtask

  task automatic do_cmd(input bit wr, input bit [31:0] addr, input int len,
                        input logic [7:0] bytes[$], input bit expect_tmo, output int lat);
    int n = 0;
    bit got = 1'b0;
    if (!expect_tmo) model_cmd(wr, addr, len, bytes);
    exp_done_q.push_back(expect_tmo);
    over = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = LEN_W'(len);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) unexpected("cmd_accept_timeout");
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    fork
      begin
        if (wr) feed(bytes);
      end
      begin
        while (!got && lat < 5000) begin
          @(negedge clk);
          lat++;
          if (done) got = 1'b1;
        end
        over = 1'b1;
      end
    join
    if (!got) unexpected("done_wait_timeout");
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int lat;
    int n;
    bit [31:0] a;
    int len;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready",  cmd_ready, 1'b1);
    check("rst_mem_valid",  bus.mem_valid, 1'b0);
    check("rst_mem_wstrb",  bus.mem_wstrb, 4'h0);
    check("rst_done",       done, 1'b0);
    check("rst_err",        err, 1'b0);
    check("rst_wdat_ready", wdat_ready, 1'b0);
    check("rst_rdat_valid", rdat_valid, 1'b0);
    check("rst_mem_instr",  bus.mem_instr, 1'b0);
    reset = 1'b0;

    // Zero-wait aligned 4-byte write: 4 fill cycles + 1 bus cycle.
    ready_mode = 1; gap_pct = 0; rrdy_mode = 2;
    fill4(8'h01, 8'h02, 8'h03, 8'h04);
    do_cmd(1'b1, 32'h400, 3, data_q, 1'b0, lat);
    check("zero_wait_latency", lat, 5);

    // Unaligned write across two words, then read it back.
    ready_mode = 0;
    fill4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    do_cmd(1'b1, 32'h102, 3, data_q, 1'b0, lat);
    do_cmd(1'b0, 32'h100, 7, data_q, 1'b0, lat);

    // Unaligned read with toggling back-pressure: expect 44, 55.
    for (int i = 0; i < 8; i++) preload(32'h200 + i, 8'(8'h11 * (i + 1)));
    rrdy_mode = 1;
    do_cmd(1'b0, 32'h203, 1, data_q, 1'b0, lat);

    // Full-length write and readback under a random bus.
    rrdy_mode = 0; gap_pct = 30;
    data_q.delete();
    for (int i = 0; i < 256; i++) data_q.push_back(8'($urandom));
    do_cmd(1'b1, 32'h0, 255, data_q, 1'b0, lat);
    do_cmd(1'b0, 32'h0, 255, data_q, 1'b0, lat);

    // Random mix of short commands.
    for (int k = 0; k < 8; k++) begin
      a = 32'h1000 + $urandom_range(0, 64);
      len = $urandom_range(0, 20);
      data_q.delete();
      for (int i = 0; i <= len; i++) data_q.push_back(8'($urandom));
      do_cmd(1'($urandom_range(0, 1)), a, len, data_q, 1'b0, lat);
    end

    // Address wrap-around.
    fill4(8'h5A, 8'h6B, 8'h7C, 8'h8D);
    do_cmd(1'b1, 32'hFFFF_FFFE, 3, data_q, 1'b0, lat);
    do_cmd(1'b0, 32'hFFFF_FFFE, 3, data_q, 1'b0, lat);

    // Timeout: bus never answers.
    ready_mode = 2; rrdy_mode = 2;
    data_q.delete();
    valid_cycles = 0;
    do_cmd(1'b0, 32'h10, 0, data_q, 1'b1, lat);
    check("timeout_valid_cycles", valid_cycles, TIMEOUT);
    @(negedge clk);
    check("timeout_valid_low", bus.mem_valid, 1'b0);

    // Reset while a write is waiting on the bus.
    gap_pct = 0;
    over = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h300; cmd_len = LEN_W'(3);
    @(negedge clk);
    cmd_valid = 1'b0;
    fill4(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    feed(data_q);
    n = 0;
    while (!bus.mem_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reset_test_reached_bus", bus.mem_valid, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midbus_reset_mem_valid", bus.mem_valid, 1'b0);
    check("midbus_reset_cmd_ready", cmd_ready, 1'b1);
    check("midbus_reset_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    check("no_partial_write", bus_rd(32'h300), 8'h00);
    ready_mode = 1;
    do_cmd(1'b0, 32'h200, 3, data_q, 1'b0, lat);

    repeat (4) @(negedge clk);
    check("exp_bus_drained",  exp_q.size(), 0);
    check("exp_rdat_drained", exp_rd_q.size(), 0);
    check("exp_done_drained", exp_done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
